uart_cmd_wrapper: RTL
=====================

Name: uart_cmd_wrapper

Overview:
- Sits directly upstream of the tour command mux. Turns the byte stream from the BLE UART receiver into 16-bit commands and drives cmd_UART / cmd_rdy_UART.
- Returns the 1-byte response (0xA5 done / 0x5A in progress) to the UART transmitter.
- Holds a two-state receive FSM with an inter-byte timeout, and an independent transmit FSM with a 1-deep pending response slot.

Parameters:
- TIMEOUT_CYC, 1000000, cycles allowed between high and low byte before the high byte is discarded (20 ms at 50 MHz).
- CNT_W, 20, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  asynchronous, active-high reset
- rx_rdy  in  1  UART receiver holds a byte; stays high until cleared
- rx_data  in  8  received byte, valid while rx_rdy high
- clr_rx_rdy  out  1  consume pulse to the UART receiver
- cmd  out  16  assembled command {high byte, low byte}; feeds cmd_UART
- cmd_rdy  out  1  command valid; feeds cmd_rdy_UART
- clr_cmd_rdy  in  1  from cmd_proc; command consumed
- send_resp  in  1  1-cycle pulse: transmit resp
- resp  in  8  response byte, sampled with send_resp
- trmt  out  1  1-cycle start pulse to the UART transmitter
- tx_data  out  8  byte to transmit; stable from trmt until tx_done
- tx_done  in  1  1-cycle pulse from the transmitter: byte sent
- tx_busy  out  1  high from trmt until tx_done of the last queued byte

Behaviour:
- Reset (rst high, async): cmd=0x0000, cmd_rdy=0, trmt=0, tx_data=0x00, tx_busy=0. Both FSMs go idle, timeout counter=0, pending slot empty. Reset mid-command drops any partial high byte.
- clr_rx_rdy is combinational: rx_rdy & (rx_state is HIGH or LOW). It is therefore asserted whenever rx_rdy is high; no byte is ever left unconsumed.
- The UART drops rx_rdy on the edge at which clr_rx_rdy is sampled. The wrapper captures each byte exactly once.
- RX FSM, state HIGH:
  - On rx_rdy, latch rx_data into high_byte, clear the counter, go to LOW.
  - Capturing a new high byte also clears cmd_rdy (overrun: the unconsumed command is abandoned).
- RX FSM, state LOW:
  - Counter increments each cycle.
  - On rx_rdy: cmd <= {high_byte, rx_data}, cmd_rdy <= 1, go to HIGH. cmd and cmd_rdy are visible the cycle after the capture edge.
  - If the counter reaches TIMEOUT_CYC-1 with rx_rdy low: discard high_byte, go to HIGH, leave cmd and cmd_rdy unchanged.
  - rx_rdy arriving on the timeout cycle wins: the byte completes the command.
- cmd only changes on a low-byte capture, so it is stable while cmd_rdy is high.
- cmd_rdy clears on the edge after clr_cmd_rdy. If a set (low-byte capture) and clr_cmd_rdy occur in the same cycle, the set wins.
- TX FSM, state TX_IDLE:
  - On send_resp: tx_data <= resp, trmt <= 1 for exactly one cycle (registered, the cycle after send_resp), go to TX_BUSY. tx_busy is high from the trmt cycle.
- TX FSM, state TX_BUSY:
  - send_resp loads resp into the pending slot and sets pend; a later send_resp overwrites the slot (newest wins).
  - On tx_done with pend set: tx_data <= pending, trmt pulses next cycle, pend cleared, stay in TX_BUSY.
  - On tx_done with pend clear: go to TX_IDLE, tx_busy drops next cycle.
  - send_resp and tx_done in the same cycle: the new resp is sent next, with no loss.
- tx_done in TX_IDLE is ignored.
- RX and TX paths are fully independent; simultaneous activity on both is legal.

Test Plan:
- Bytes 0x45 then 0x23 (rx_rdy pulses 10 cycles apart) -> cmd=0x4523, cmd_rdy=1 the cycle after the second capture; clr_rx_rdy exactly 2 cycles total; clr_cmd_rdy -> cmd_rdy=0 next cycle.
- High byte 0x41, no low byte for TIMEOUT_CYC cycles (set TIMEOUT_CYC=100), then 0x50, 0x00 -> no command from 0x41; result cmd=0x5000.
- Low-byte capture in the same cycle as clr_cmd_rdy for the previous command -> cmd_rdy stays 1 with the new cmd value.
- Command 0x4523 left unconsumed, then new high byte 0x60 -> cmd_rdy drops on that capture; after 0x01, cmd=0x6001, cmd_rdy=1.
- send_resp resp=0x5A -> trmt single pulse the next cycle, tx_data=0x5A, tx_busy=1 until tx_done, then 0.
- send_resp 0x5A, then while busy send_resp 0x11 and 0xA5 -> after tx_done a second trmt with tx_data=0xA5 (0x11 dropped); tx_busy falls only after the second tx_done. Assert rst mid-transfer -> all outputs at reset values immediately.

Source files
------------

// File: rtl/uart_cmd_wrapper.sv
// rtl/uart_cmd_wrapper.sv - UART byte stream to 16-bit command assembler plus 1-byte response transmitter
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rx_rdy, rx_data          received byte from the UART receiver
//   clr_rx_rdy               consume strobe back to the receiver (combinational)
//   cmd, cmd_rdy             assembled {high, low} command and its valid flag
//   clr_cmd_rdy              command consumed by the downstream processor
//   send_resp, resp          request to transmit a response byte
//   trmt, tx_data            start pulse and byte to the UART transmitter
//   tx_done                  transmitter finished the current byte
//   tx_busy                  a response byte is in flight or queued
module uart_cmd_wrapper #(
    parameter int TIMEOUT_CYC = 1000000,
    parameter int CNT_W       = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        tx_busy
);

    typedef enum logic {RX_HIGH, RX_LOW} rx_state_t;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

    rx_state_t        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] rx_cnt;
    logic [7:0]       high_byte;
    logic             capture_high, capture_low, timeout_hit;

    tx_state_t        tx_state, tx_state_nxt;
    logic             pend;
    logic [7:0]       pend_data;
    logic             load_tx, pend_set, pend_clr;
    logic [7:0]       tx_load_data;

    // Every byte presented is consumed in either RX state, so nothing stalls the receiver.
    assign clr_rx_rdy  = rx_rdy & ((rx_state == RX_HIGH) || (rx_state == RX_LOW));
    assign timeout_hit = (rx_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign tx_busy     = (tx_state == TX_BUSY);

    always_comb begin
        rx_state_nxt = rx_state;
        capture_high = 1'b0;
        capture_low  = 1'b0;
        case (rx_state)
            RX_HIGH: begin
                if (rx_rdy) begin
                    capture_high = 1'b1;
                    rx_state_nxt = RX_LOW;
                end
            end
            RX_LOW: begin
                // A byte arriving on the timeout cycle still completes the command.
                if (rx_rdy) begin
                    capture_low  = 1'b1;
                    rx_state_nxt = RX_HIGH;
                end else if (timeout_hit) begin
                    rx_state_nxt = RX_HIGH;
                end
            end
            default: rx_state_nxt = RX_HIGH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state  <= RX_HIGH;
            rx_cnt    <= '0;
            high_byte <= 8'h00;
            cmd       <= 16'h0000;
            cmd_rdy   <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            if (capture_high) begin
                high_byte <= rx_data;
                rx_cnt    <= '0;
            end else if (rx_state == RX_LOW) begin
                rx_cnt <= rx_cnt + CNT_W'(1);
            end
            if (capture_low) begin
                cmd <= {high_byte, rx_data};
            end
            // A completed command beats a consume in the same cycle; a fresh high byte
            // abandons any command nobody picked up.
            if (capture_low) begin
                cmd_rdy <= 1'b1;
            end else if (capture_high || clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        load_tx      = 1'b0;
        tx_load_data = resp;
        pend_set     = 1'b0;
        pend_clr     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (send_resp) begin
                    load_tx      = 1'b1;
                    tx_state_nxt = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_done) begin
                    // A response arriving with tx_done is newer than anything pending.
                    if (send_resp) begin
                        load_tx  = 1'b1;
                        pend_clr = 1'b1;
                    end else if (pend) begin
                        load_tx      = 1'b1;
                        tx_load_data = pend_data;
                        pend_clr     = 1'b1;
                    end else begin
                        tx_state_nxt = TX_IDLE;
                    end
                end else if (send_resp) begin
                    pend_set = 1'b1;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            trmt      <= 1'b0;
            tx_data   <= 8'h00;
            pend      <= 1'b0;
            pend_data <= 8'h00;
        end else begin
            tx_state <= tx_state_nxt;
            trmt     <= load_tx;
            if (load_tx) begin
                tx_data <= tx_load_data;
            end
            if (pend_set) begin
                pend      <= 1'b1;
                pend_data <= resp;
            end else if (pend_clr) begin
                pend <= 1'b0;
            end
        end
    end

endmodule
